// File: rtl/nanorv32_intc_pkg.sv
// Shared constants for the nanorv32 interrupt controller: register offsets,
// FSM state encoding and interrupt id width.
package nanorv32_intc_pkg;

  localparam int ID_W   = 3;
  localparam int NB_MAX = 8;

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h4;
  localparam logic [3:0] ADDR_EDGE    = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/nanorv32_intc_prio.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module nanorv32_intc_prio
  import nanorv32_intc_pkg::*;
(
  input  logic [NB_MAX-1:0] req,
  output logic [ID_W-1:0]   id,
  output logic              any
);

  always_comb begin
    id  = '0;
    any = |req;
    for (int i = NB_MAX - 1; i >= 0; i--)
      if (req[i]) id = ID_W'(i);
  end

endmodule

// File: rtl/nanorv32_intc.sv
// nanorv32 interrupt controller: synchronised level/edge lines, enable mask,
// lowest-index arbitration and an IDLE/REQ/SERVICE handshake with the CPU.
// Edge-triggered lines are built only when NANORV32_INTC_EDGE_EN is defined.
module nanorv32_intc
  import nanorv32_intc_pkg::*;
#(
  parameter int NB_IRQ = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      irqs,
  input  logic            reg_sel,
  input  logic            reg_we,
  input  logic [3:0]      reg_addr,
  input  logic [7:0]      reg_wdata,
  output logic [7:0]      reg_rdata,
  output logic            irq_req,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack,
  input  logic            irq_eoi
);

  localparam logic [7:0] LINE_MASK = 8'((16'd1 << NB_IRQ) - 16'd1);

  logic [7:0]      sync_q;
  logic [7:0]      enable_r;
  logic [7:0]      pending;
  logic [7:0]      edge_rd;
  logic [7:0]      active;
  logic [ID_W-1:0] win_id;
  logic            win_any;
  logic [ID_W-1:0] svc_id;
  state_t          state;
  logic            wr;
  logic            ack_claim;

  assign wr        = reg_sel & reg_we;
  assign ack_claim = (state == ST_REQ) & irq_ack;

  // Unused lines are masked here so nothing downstream ever sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      enable_r <= '0;
    end else begin
      sync_q <= irqs & LINE_MASK;
      if (wr && reg_addr == ADDR_ENABLE) enable_r <= reg_wdata;
    end
  end

`ifdef NANORV32_INTC_EDGE_EN
  logic [7:0] sync_d;
  logic [7:0] edge_r;
  logic [7:0] edge_pend;
  logic [7:0] rise;
  logic [7:0] clr;

  assign rise = sync_q & ~sync_d & edge_r;
  assign clr  = ((wr && reg_addr == ADDR_PENDING) ? reg_wdata : 8'h00)
              | (ack_claim ? 8'(8'd1 << irq_id) : 8'h00);

  // A rising edge in the same cycle as a clear keeps the pending bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d    <= '0;
      edge_r    <= '0;
      edge_pend <= '0;
    end else begin
      sync_d    <= sync_q;
      edge_pend <= (edge_pend & ~clr) | rise;
      if (wr && reg_addr == ADDR_EDGE) edge_r <= reg_wdata & LINE_MASK;
    end
  end

  assign pending = (sync_q & ~edge_r) | (edge_pend & edge_r);
  assign edge_rd = edge_r;
`else
  assign pending = sync_q;
  assign edge_rd = 8'h00;
`endif

  assign active = pending & enable_r;

  nanorv32_intc_prio u_prio (
    .req (active),
    .id  (win_id),
    .any (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
      svc_id  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (win_any) begin
          state   <= ST_REQ;
          irq_req <= 1'b1;
          irq_id  <= win_id;
        end
        ST_REQ: if (irq_ack) begin
          svc_id  <= irq_id;
          state   <= ST_SERVICE;
          irq_req <= 1'b0;
        end else if (!win_any) begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end else begin
          irq_id <= win_id;
        end
        ST_SERVICE: if (irq_eoi) state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    if (reg_sel) begin
      case (reg_addr)
        ADDR_ENABLE:  reg_rdata = enable_r;
        ADDR_PENDING: reg_rdata = pending;
        ADDR_EDGE:    reg_rdata = edge_rd;
        ADDR_STATUS:  reg_rdata = {2'b00, state, 1'b0, svc_id};
        default:      reg_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_nanorv32_intc.sv
// Directed self-checking bench for nanorv32_intc; edge-line scenarios are
// exercised when NANORV32_INTC_EDGE_EN is defined, otherwise the level-only build.
module tb_nanorv32_intc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irqs = '0;
  logic       reg_sel = 1'b0, reg_we = 1'b0;
  logic [3:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack = 1'b0, irq_eoi = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] d;

  nanorv32_intc #(.NB_IRQ(8)) dut (
    .clk(clk), .rst(rst), .irqs(irqs), .reg_sel(reg_sel), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_eoi(irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = v;
    tick();
    reg_sel = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
    #1 v = reg_rdata;
    reg_sel = 1'b0;
  endtask

  task automatic do_reset();
    irqs = '0; irq_ack = 0; irq_eoi = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", irq_req); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    rd(4'hC, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", d); end
    rd(4'h0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_enable got=%h exp=00", d); end
  endtask

  task automatic test_level();
    do_reset();
    wr(4'h0, 8'h01);
    irqs = 8'h01;
    tick();  // E0
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL lvl_e0_req got=%b exp=0", irq_req); end
    tick();  // E1
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL lvl_e1 got=%b/%0d exp=1/0", irq_req, irq_id); end
    rd(4'h4, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL lvl_pending got=%h exp=01", d); end
    irq_ack = 1; tick(); irq_ack = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h20 || irq_req !== 1'b0) begin errors++; $display("FAIL lvl_service got=%h/%b exp=20/0", d, irq_req); end
    irq_ack = 1; tick(); irq_ack = 0; tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL lvl_svc_hold got=%b exp=0", irq_req); end
    irq_eoi = 1; tick(); irq_eoi = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h00 || irq_req !== 1'b0) begin errors++; $display("FAIL lvl_eoi got=%h/%b exp=00/0", d, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL lvl_rereq got=%b/%0d exp=1/0", irq_req, irq_id); end
    irqs = 8'h00; tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL lvl_drop got=%b exp=0", irq_req); end
    reg_addr = 4'h0; #1;
    checks++; if (reg_rdata !== 8'h00) begin errors++; $display("FAIL rdata_nosel got=%h exp=00", reg_rdata); end
    rd(4'h2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd_unmapped got=%h exp=00", d); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(4'h0, 8'hFF);
    irqs = 8'h0C; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL prio_id2 got=%b/%0d exp=1/2", irq_req, irq_id); end
    irq_ack = 1; tick(); irq_ack = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL prio_status got=%h exp=22", d); end
    irqs = 8'h08;
    irq_eoi = 1; tick(); irq_eoi = 0; tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL prio_id3 got=%b/%0d exp=1/3", irq_req, irq_id); end
    irqs = 8'h09; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL prio_rereg got=%b/%0d exp=1/0", irq_req, irq_id); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    wr(4'h0, 8'h01);
    irqs = 8'h01; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL endrop_req got=%b/%0d exp=1/0", irq_req, irq_id); end
    wr(4'h0, 8'h00);
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL endrop_drop got=%b exp=0", irq_req); end
    irq_ack = 1; tick(); irq_ack = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h00 || irq_req !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL endrop_ack got=%h/%b/%0d exp=00/0/0", d, irq_req, irq_id); end
  endtask

  task automatic test_reset_in_service();
    do_reset();
    wr(4'h0, 8'hFF);
    irqs = 8'h20; tick(); tick();
    irq_ack = 1; tick(); irq_ack = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h25) begin errors++; $display("FAIL rsv_pre got=%h exp=25", d); end
    irqs = 8'h00; rst = 1; tick(); rst = 0;
    rd(4'hC, d);
    checks++; if (d !== 8'h00 || irq_req !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL rsv_status got=%h/%b/%0d exp=00/0/0", d, irq_req, irq_id); end
    rd(4'h0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rsv_enable got=%h exp=00", d); end
  endtask

`ifdef NANORV32_INTC_EDGE_EN
  task automatic test_edge();
    do_reset();
    wr(4'h8, 8'h02); wr(4'h0, 8'h02);
    irqs = 8'h02; tick(); irqs = 8'h00;  // E0
    tick();  // E1
    rd(4'h4, d);
    checks++; if (d !== 8'h02 || irq_req !== 1'b0) begin errors++; $display("FAIL edge_e1 got=%h/%b exp=02/0", d, irq_req); end
    tick();  // E2
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL edge_e2 got=%b/%0d exp=1/1", irq_req, irq_id); end
    irq_ack = 1; tick(); irq_ack = 0;
    rd(4'h4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_ack_clr got=%h exp=00", d); end
  endtask

  task automatic test_edge_w1c();
    do_reset();
    wr(4'h8, 8'h02); wr(4'h0, 8'h02);
    irqs = 8'h02; tick(); irqs = 8'h00;  // E0
    wr(4'h4, 8'h02);                     // E1: set and clear together
    rd(4'h4, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL w1c_setwins got=%h exp=02", d); end
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL w1c_req got=%b exp=1", irq_req); end
    wr(4'h4, 8'h02);
    rd(4'h4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_clear got=%h exp=00", d); end
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL w1c_drop got=%b exp=0", irq_req); end
  endtask
`else
  task automatic test_level_only();
    do_reset();
    wr(4'h8, 8'hFF);
    rd(4'h8, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_rd0 got=%h exp=00", d); end
    irqs = 8'h02; tick();
    wr(4'h4, 8'h02);
    rd(4'h4, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL lvl_w1c_ign got=%h exp=02", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_enable_drop();
    test_reset_in_service();
`ifdef NANORV32_INTC_EDGE_EN
    test_edge();
    test_edge_w1c();
`else
    test_level_only();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
